vx_icache_mem_bridge: RTL and testbench

- Sits directly below the core pipeline's instruction-cache port.
- Accepts tagged icache requests (valid/addr/tag/ready) and forwards them to an untagged, in-order instruction memory bus.
- Tracks outstanding tags in a FIFO, re-attaches the tag to each in-order memory response, and returns it through a registered response stage.
- Bounds in-flight requests with a credit counter so responses never overflow.

---
 rtl/vx_icache_bridge_pkg.sv | 27 ++
 rtl/vx_tag_fifo.sv | 65 ++++++
 rtl/vx_icache_mem_bridge.sv | 151 +++++++++++++++
 tb/tb_vx_icache_mem_bridge.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_icache_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vx_icache_bridge_pkg
// Description : Shared types and sizing helpers for the icache/memory bridge.
// Revision    : 1.0  initial release
// ============================================================================
package vx_icache_bridge_pkg;

  localparam int TAG_WIDTH_DEF       = 8;
  localparam int MAX_OUTSTANDING_DEF = 4;
  localparam int ADDR_WIDTH_DEF      = 30;

  // Counter width able to hold MAX_OUTSTANDING itself (not just MAX-1)
  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING_DEF + 1);

  typedef struct packed {
    logic [31:0]              data;
    logic [TAG_WIDTH_DEF-1:0] tag;
  } rsp_entry_t;

  // Same sizing rule as CNT_WIDTH, for non-default MAX_OUTSTANDING
  function automatic int cnt_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vx_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vx_tag_fifo
// Description : Synchronous FIFO for outstanding request tags. Push and pop
//               may coincide at any occupancy; when empty, a same-cycle
//               push is bypassed straight to pop_data.
// Revision    : 1.0  initial release
// ============================================================================
module vx_tag_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en, rd_en;

  // Status flags, bypass read and pointer/occupancy next-state
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == DEPTH_CNT);
    pop_data = empty ? push_data : mem_q[rd_ptr_q];
    // Empty with push+pop: the entry goes straight through, nothing stored
    wr_en    = push && (!full || pop) && !(empty && pop);
    rd_en    = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    count_d  = count_q + CW'(wr_en) - CW'(rd_en);
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage; contents are qualified by count, so no reset needed
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/vx_icache_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : vx_icache_mem_bridge
// Description : Forwards tagged icache requests to an untagged in-order
//               memory bus, re-attaches tags to responses through a one-entry
//               response register, and bounds in-flight requests by credits.
//               Define VX_ICACHE_BRIDGE_PERF_EN to add request/stall counters.
// Revision    : 1.0  initial release
// ============================================================================
module vx_icache_mem_bridge
  import vx_icache_bridge_pkg::*;
#(
  parameter int TAG_WIDTH       = TAG_WIDTH_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  icache_req_valid,
  input  logic [ADDR_WIDTH-1:0] icache_req_addr,
  input  logic [TAG_WIDTH-1:0]  icache_req_tag,
  output logic                  icache_req_ready,
  output logic                  icache_rsp_valid,
  output logic [31:0]           icache_rsp_data,
  output logic [TAG_WIDTH-1:0]  icache_rsp_tag,
  input  logic                  icache_rsp_ready,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_rsp_valid,
  input  logic [31:0]           mem_rsp_data,
  output logic                  mem_rsp_ready,
  output logic                  busy,
  output logic                  err
`ifdef VX_ICACHE_BRIDGE_PERF_EN
  ,
  output logic [31:0]           perf_req_count,
  output logic [31:0]           perf_stall_count
`endif
);

  localparam int CW = cnt_width(MAX_OUTSTANDING);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  typedef struct packed {
    logic [31:0]          data;
    logic [TAG_WIDTH-1:0] tag;
  } rsp_reg_t;

  logic [CW-1:0]        outstanding_q, outstanding_d;
  rsp_reg_t             rsp_q, rsp_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 err_q, err_d;
  logic                 can_issue, req_fire, rsp_fire, mem_fire;
  logic                 tag_avail, load_rsp;
  logic                 fifo_full, fifo_empty;
  logic [TAG_WIDTH-1:0] fifo_head;

  // Handshakes; outputs are forced low while reset is held
  always_comb begin
    can_issue        = (outstanding_q < MAX_CNT);
    icache_req_ready = reset && mem_req_ready && can_issue;
    mem_req_valid    = reset && icache_req_valid && can_issue;
    mem_req_addr     = icache_req_addr;
    mem_rsp_ready    = reset && (!rsp_valid_q || icache_rsp_ready);
    req_fire         = icache_req_valid && icache_req_ready;
    rsp_fire         = rsp_valid_q && icache_rsp_ready;
    mem_fire         = mem_rsp_valid && mem_rsp_ready;
    // A tag pushed this very cycle may be consumed by the bypass path
    tag_avail        = !fifo_empty || req_fire;
    load_rsp         = mem_fire && tag_avail;
  end

  vx_tag_fifo #(
    .WIDTH (TAG_WIDTH),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (req_fire),
    .push_data (icache_req_tag),
    .pop       (load_rsp),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Credits, response register and sticky error next-state
  always_comb begin
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
    rsp_valid_d   = rsp_valid_q;
    rsp_d         = rsp_q;
    if (load_rsp) begin
      rsp_valid_d = 1'b1;
      rsp_d.data  = mem_rsp_data;
      rsp_d.tag   = fifo_head;
    end else if (rsp_fire) begin
      rsp_valid_d = 1'b0;
    end
    err_d = err_q || (mem_fire && !tag_avail)
                  || (req_fire && fifo_full && !load_rsp);
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_q         <= '0;
      err_q         <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_q         <= rsp_d;
      err_q         <= err_d;
    end
  end

  assign icache_rsp_valid = rsp_valid_q;
  assign icache_rsp_data  = rsp_q.data;
  assign icache_rsp_tag   = rsp_q.tag;
  assign busy             = (outstanding_q != '0) || rsp_valid_q;
  assign err              = err_q;

`ifdef VX_ICACHE_BRIDGE_PERF_EN
  logic [31:0] perf_req_q, perf_req_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Free-running event counters, wrapping modulo 2^32
  always_comb begin
    perf_req_d   = perf_req_q + 32'(req_fire);
    perf_stall_d = perf_stall_q + 32'(icache_req_valid && !icache_req_ready);
  end

  // Counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_req_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_req_q   <= perf_req_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_req_count   = perf_req_q;
  assign perf_stall_count = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vx_icache_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_vx_icache_mem_bridge
// Description : Scoreboard bench for vx_icache_mem_bridge with an in-order
//               memory model and directed request vectors.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vx_icache_mem_bridge;

  localparam int TW = 8;
  localparam int AW = 30;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          icache_req_valid = 1'b0;
  logic [AW-1:0] icache_req_addr = '0;
  logic [TW-1:0] icache_req_tag = '0;
  logic          icache_req_ready;
  logic          icache_rsp_valid;
  logic [31:0]   icache_rsp_data;
  logic [TW-1:0] icache_rsp_tag;
  logic          icache_rsp_ready = 1'b0;
  logic          mem_req_valid;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_ready = 1'b1;
  logic          mem_rsp_valid = 1'b0;
  logic [31:0]   mem_rsp_data = '0;
  logic          mem_rsp_ready;
  logic          busy;
  logic          err;
`ifdef VX_ICACHE_BRIDGE_PERF_EN
  logic [31:0]   perf_req_count;
  logic [31:0]   perf_stall_count;
`endif

  vx_icache_mem_bridge #(.TAG_WIDTH(TW), .MAX_OUTSTANDING(MO), .ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .reset            (reset),
    .icache_req_valid (icache_req_valid),
    .icache_req_addr  (icache_req_addr),
    .icache_req_tag   (icache_req_tag),
    .icache_req_ready (icache_req_ready),
    .icache_rsp_valid (icache_rsp_valid),
    .icache_rsp_data  (icache_rsp_data),
    .icache_rsp_tag   (icache_rsp_tag),
    .icache_rsp_ready (icache_rsp_ready),
    .mem_req_valid    (mem_req_valid),
    .mem_req_addr     (mem_req_addr),
    .mem_req_ready    (mem_req_ready),
    .mem_rsp_valid    (mem_rsp_valid),
    .mem_rsp_data     (mem_rsp_data),
    .mem_rsp_ready    (mem_rsp_ready),
    .busy             (busy),
    .err              (err)
`ifdef VX_ICACHE_BRIDGE_PERF_EN
    ,
    .perf_req_count   (perf_req_count),
    .perf_stall_count (perf_stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [TW-1:0] tag; logic [31:0] data; } req_t;
  typedef struct { logic [31:0] data; logic [TW-1:0] tag; } exp_t;
  typedef struct { logic [31:0] data; int due; } mem_t;

  req_t req_q[$];
  exp_t sb_q[$];
  mem_t mem_q[$];
  int   rsp_cyc[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, out_m = 0, acc_cnt = 0, mem_lat = 0;
  bit mem_en = 1'b1, rsp_rdy = 1'b1, spur = 1'b0, spur_drv = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [TW-1:0] t, input logic [31:0] d);
    req_q.push_back('{a, t, d});
    sb_q.push_back('{d, t});
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_q.size() == 0 && sb_q.size() == 0 && mem_q.size() == 0) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL %s: drain timeout, %0d responses still expected", name, sb_q.size());
  endtask

  // Driver, memory model and response monitor
  initial begin
    bit req_f, mem_f, rsp_f, last_memrsp, prev_hold;
    logic [31:0] prev_data;
    logic [TW-1:0] prev_tag;
    exp_t e;
    req_t r;
    last_memrsp = 1'b0;
    prev_hold = 1'b0;
    prev_data = '0;
    prev_tag = '0;
    forever begin
      @(negedge clk);
      req_f = 1'b0; mem_f = 1'b0; rsp_f = 1'b0;
      if (!reset) begin
        last_memrsp = 1'b0;
        prev_hold = 1'b0;
      end else begin
        req_f = icache_req_valid && icache_req_ready;
        mem_f = mem_rsp_valid && mem_rsp_ready;
        rsp_f = icache_rsp_valid && icache_rsp_ready;
        chk("req_ready", icache_req_ready, 64'(mem_req_ready && out_m < MO));
        chk("mem_req_valid", mem_req_valid, 64'(icache_req_valid && out_m < MO));
        chk("busy", busy, 64'((out_m != 0) || icache_rsp_valid));
        if (req_f && req_q.size() > 0) chk("mem_req_addr", mem_req_addr, req_q[0].addr);
        if (last_memrsp) chk("rsp_latency", icache_rsp_valid, 1);
        if (prev_hold) begin
          chk("hold_valid", icache_rsp_valid, 1);
          chk("hold_data", icache_rsp_data, prev_data);
          chk("hold_tag", icache_rsp_tag, prev_tag);
        end
        if (rsp_f) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rsp: got data %0h tag %0h expected none",
                     icache_rsp_data, icache_rsp_tag);
          end else begin
            e = sb_q.pop_front();
            chk("rsp_data", icache_rsp_data, e.data);
            chk("rsp_tag", icache_rsp_tag, e.tag);
          end
          rsp_cyc.push_back(cyc);
        end
        last_memrsp = mem_f && !spur_drv;
        prev_hold = icache_rsp_valid && !icache_rsp_ready;
        prev_data = icache_rsp_data;
        prev_tag = icache_rsp_tag;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!reset) begin
        req_q.delete(); mem_q.delete(); sb_q.delete();
        out_m = 0;
        spur = 1'b0; spur_drv = 1'b0;
        icache_req_valid = 1'b0;
        mem_rsp_valid = 1'b0;
        icache_rsp_ready = rsp_rdy;
        continue;
      end
      if (req_f) begin
        r = req_q.pop_front();
        mem_q.push_back('{r.data, cyc + mem_lat});
        acc_cnt++;
      end
      if (mem_f && !spur_drv && mem_q.size() > 0) void'(mem_q.pop_front());
      out_m += int'(req_f) - int'(rsp_f);
      icache_req_valid = (req_q.size() > 0);
      if (req_q.size() > 0) begin
        icache_req_addr = req_q[0].addr;
        icache_req_tag = req_q[0].tag;
      end
      if (spur) begin
        spur = 1'b0;
        spur_drv = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 32'hDEAD_BEEF;
      end else begin
        spur_drv = 1'b0;
        mem_rsp_valid = mem_en && mem_q.size() > 0 && cyc >= mem_q[0].due;
        mem_rsp_data = (mem_q.size() > 0) ? mem_q[0].data : 32'h0;
      end
      icache_rsp_ready = rsp_rdy;
    end
  end

  // Directed stimulus
  initial begin
    int base;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", icache_rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_req_ready", icache_req_ready, 0);
    chk("rst_mem_rsp_ready", mem_rsp_ready, 0);
    @(posedge clk); #2 reset = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", icache_req_ready, 1);

    // Single fetch, memory answers three cycles after the request
    mem_lat = 2;
    issue(30'h100, 8'h03, 32'h0000_0013);
    wait_drain("single");
    @(negedge clk);
    chk("single_busy_drop", busy, 0);

    // Credit limit: 6 requests with memory stalled
    mem_lat = 0;
    mem_en = 1'b0;
    base = acc_cnt;
    for (int i = 0; i < 6; i++) issue(30'h200 + 30'(i), 8'h10 + 8'(i), 32'h1000_0000 + 32'(i * 17));
    repeat (10) @(negedge clk);
    chk("credit_accepted", acc_cnt - base, 4);
    chk("credit_ready_low", icache_req_ready, 0);
    chk("credit_busy", busy, 1);
    mem_en = 1'b1;
    wait_drain("credit");
    chk("credit_all", acc_cnt - base, 6);

    // Backpressure: responses held while the pipeline stalls
    mem_en = 1'b0;
    rsp_rdy = 1'b0;
    base = acc_cnt;
    for (int i = 0; i < 4; i++) issue(30'h300 + 30'(i), 8'(i), 32'hC0DE_0000 + 32'(i));
    repeat (6) @(negedge clk);
    chk("bp_accepted", acc_cnt - base, 4);
    mem_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("bp_held_valid", icache_rsp_valid, 1);
    chk("bp_held_tag", icache_rsp_tag, 0);
    chk("bp_held_data", icache_rsp_data, 32'hC0DE_0000);
    chk("bp_mem_rsp_ready", mem_rsp_ready, 0);
    chk("bp_mem_waiting", mem_rsp_valid, 1);
    rsp_rdy = 1'b1;
    wait_drain("backpressure");

    // Full throughput: one response per cycle
    rsp_cyc.delete();
    for (int i = 0; i < 8; i++) issue(30'h400 + 30'(i), 8'h80 + 8'(i), 32'h5A5A_0000 + 32'(i));
    wait_drain("throughput");
    chk("tp_count", rsp_cyc.size(), 8);
    if (rsp_cyc.size() == 8) chk("tp_span", rsp_cyc[7] - rsp_cyc[0], 7);

    // Spurious memory response
    repeat (2) @(negedge clk);
    chk("spur_err_before", err, 0);
    spur = 1'b1;
    repeat (4) @(negedge clk);
    chk("spur_err", err, 1);
    chk("spur_no_rsp", icache_rsp_valid, 0);
    chk("spur_busy", busy, 0);
    issue(30'h500, 8'h55, 32'h1234_5678);
    wait_drain("after_spur");
    chk("spur_sticky", err, 1);

    // Asynchronous reset with three requests in flight
    mem_en = 1'b0;
    base = acc_cnt;
    for (int i = 0; i < 3; i++) issue(30'h600 + 30'(i), 8'hA0 + 8'(i), 32'hFACE_0000 + 32'(i));
    repeat (6) @(negedge clk);
    chk("mid_accepted", acc_cnt - base, 3);
    chk("mid_busy", busy, 1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_err", err, 0);
    chk("arst_rsp_valid", icache_rsp_valid, 0);
    chk("arst_req_ready", icache_req_ready, 0);
    chk("arst_mem_req_valid", mem_req_valid, 0);
    chk("arst_mem_rsp_ready", mem_rsp_ready, 0);
    repeat (2) @(negedge clk);
    mem_en = 1'b1;
    @(posedge clk); #2 reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_busy", busy, 0);
    chk("post_err", err, 0);
    chk("post_rsp_valid", icache_rsp_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
